uart_tx: RTL and testbench

- 8N1 UART transmitter; the transmit-side counterpart of the design's UART receiver.
- Serializes one byte per request onto TX at BAUD_DIV clocks per bit. Frame is start (0), data LSB-first, stop (1).
- Sits between command/response logic and the physical TX pin.
- Default timing (2604 clk/bit) matches the receiver.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_if.sv | 27 ++
 rtl/uart_tx.sv | 106 ++++++++++
 tb/tb_uart_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state type and frame-load helper.
// Optional even parity (8E1) is selected with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } uart_tx_state_t;

    localparam int UART_BAUD_DIV_DFLT = 2604;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

    // Stop bit is shifted in, so the register holds one bit less
    // than the frame.
    localparam int UART_SHIFT_BITS = UART_FRAME_BITS - 1;

    // Build the shift-register image of a frame: start bit in bit 0,
    // data LSB-first above it, parity (if enabled) on top.
    function automatic logic [UART_SHIFT_BITS-1:0] uart_tx_load(
        input logic [7:0] d
    );
`ifdef UART_TX_PARITY_EN
        return {^d, d, 1'b0};
`else
        return {d, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmit request / status bundle between command logic and uart_tx.
// master drives requests, slave (the transmitter) drives line and status.
interface uart_tx_if;

    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       busy;
    logic       tx_done;

    modport master (
        output trmt,
        output tx_data,
        input  TX,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  trmt,
        input  tx_data,
        output TX,
        output busy,
        output tx_done
    );

endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, BAUD_DIV clocks per bit, registered TX.
// Define UART_TX_PARITY_EN for an 8E1 frame (even parity before stop).
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_if.slave    bus
);

    localparam logic [0:0]  ST_IDLE   = IDLE;
    localparam logic [0:0]  ST_TX     = TRANSMIT;
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'(UART_FRAME_BITS - 1);
    localparam int          SW        = UART_SHIFT_BITS;

    logic [0:0]    r_state;
    logic [SW-1:0] r_shift;
    logic [11:0]   r_baud;
    logic [3:0]    r_bit;
    logic          r_busy;
    logic          r_done;

    logic          w_idle;
    logic          w_load;
    logic          w_tick;
    logic          w_last;

    assign w_idle = (r_state == ST_IDLE);
    assign w_load = w_idle && bus.trmt;
    assign w_tick = !w_idle && (r_baud == BAUD_LAST);
    assign w_last = w_tick && (r_bit == BIT_LAST);

    // FSM: leave IDLE on an accepted request, return on the last shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (w_load) begin
            r_state <= ST_TX;
        end else if (w_last) begin
            r_state <= ST_IDLE;
        end
    end

    // busy spans load edge to completion edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else if (w_load) begin
            r_busy <= 1'b1;
        end else if (w_last) begin
            r_busy <= 1'b0;
        end
    end

    // tx_done is sticky; only a newly accepted request clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else if (w_load) begin
            r_done <= 1'b0;
        end else if (w_last) begin
            r_done <= 1'b1;
        end
    end

    // Baud counter: runs only while transmitting, holds 0 in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud <= 12'd0;
        end else if (w_load || w_tick) begin
            r_baud <= 12'd0;
        end else if (!w_idle) begin
            r_baud <= r_baud + 12'd1;
        end
    end

    // Bit counter: number of shifts done in the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit <= 4'd0;
        end else if (w_load) begin
            r_bit <= 4'd0;
        end else if (w_tick) begin
            r_bit <= r_bit + 4'd1;
        end
    end

    // Shift register: load frame image, shift right filling with 1s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '1;
        end else if (w_load) begin
            r_shift <= uart_tx_load(bus.tx_data);
        end else if (w_tick) begin
            r_shift <= {1'b1, r_shift[SW-1:1]};
        end
    end

    assign bus.TX      = r_shift[0];
    assign bus.busy    = r_busy;
    assign bus.tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a serial monitor decodes TX frames
// and checks them, plus done latency, against queued expectations.
module tb_uart_tx;

    localparam int BD = 20;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int LAT = FB * BD;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_err;

    logic [8:0] exp_q[$];

    uart_tx_if bus();

    uart_tx #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [FB-1:0] frame(input logic [8:0] e);
`ifdef UART_TX_PARITY_EN
        return {1'b1, e[0], e[8:1], 1'b0};
`else
        return {1'b1, e[8:1], 1'b0};
`endif
    endfunction

    // Monitor: decode frames mid-bit and check done latency
    logic          mon_act;
    int            mon_cnt;
    logic [FB-1:0] mon_bits;
    logic          prev_busy;
    logic          prev_done;
    logic          t_valid;
    int            load_cyc;
    logic [8:0]    mon_e;

    initial begin
        mon_act   = 1'b0;
        mon_cnt   = 0;
        mon_bits  = '0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        t_valid   = 1'b0;
        load_cyc  = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act   = 1'b0;
            t_valid   = 1'b0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy && !prev_busy) begin
                load_cyc = cyc;
                t_valid  = 1'b1;
            end
            if (bus.tx_done && !prev_done) begin
                chk("done_valid", 32'(t_valid), 32'd1);
                chk("done_lat", 32'(cyc - load_cyc), 32'(LAT));
                t_valid = 1'b0;
            end
            prev_busy = bus.busy;
            prev_done = bus.tx_done;
            if (!mon_act && bus.TX == 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
            if (mon_act) begin
                if (mon_cnt % BD == BD / 2) begin
                    mon_bits[mon_cnt / BD] = bus.TX;
                    chk("busy_mid", 32'(bus.busy), 32'd1);
                    if (mon_cnt / BD == FB - 1) begin
                        mon_act = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("sb_empty", 32'(mon_bits), 32'hDEAD);
                        end else begin
                            mon_e = exp_q.pop_front();
                            chk($sformatf("frame_%02h", mon_e[8:1]),
                                32'(mon_bits), 32'(frame(mon_e)));
                        end
                    end
                end
                mon_cnt++;
            end
        end
    end

    // Assumes caller is at a negedge with the DUT idle
    task automatic send(input logic [7:0] d, input logic p,
                        input bit hold);
        bus.trmt    = 1'b1;
        bus.tx_data = d;
        exp_q.push_back({d, p});
        if (!hold) begin
            @(negedge clk);
            bus.trmt = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * LAT && !seen; i++) begin
            if (bus.tx_done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        bus.trmt    = 1'b0;
        bus.tx_data = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(bus.TX), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx", 32'(bus.TX), 32'd1);

        // A5 with a mid-frame FF request that must be ignored
        send(8'hA5, 1'b0, 1'b0);
        chk("start_tx", 32'(bus.TX), 32'd0);
        chk("start_busy", 32'(bus.busy), 32'd1);
        repeat (4 * BD - 1) @(negedge clk);
        bus.trmt    = 1'b1;
        bus.tx_data = 8'hFF;
        @(negedge clk);
        bus.trmt    = 1'b0;
        bus.tx_data = 8'h11;
        wait_done();
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_tx", 32'(bus.TX), 32'd1);

        // Back-to-back, each issued one cycle after tx_done rises
        send(8'h00, 1'b0, 1'b0);
        wait_done();
        send(8'hFF, 1'b0, 1'b0);
        wait_done();
        send(8'h5A, 1'b0, 1'b0);
        wait_done();

        // Reset mid-frame
        send(8'h3C, 1'b0, 1'b0);
        repeat (LAT / 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx", 32'(bus.TX), 32'd1);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.tx_done), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(8'hC3, 1'b0, 1'b0);
        wait_done();

        // trmt held across completion: reload one cycle after done
        @(negedge clk);
        send(8'h81, 1'b0, 1'b1);
        @(negedge clk);
        wait_done();
        bus.tx_data = 8'h7E;
        exp_q.push_back({8'h7E, 1'b0});
        @(negedge clk);
        bus.trmt = 1'b0;
        chk("held_tx", 32'(bus.TX), 32'd0);
        chk("held_busy", 32'(bus.busy), 32'd1);
        chk("held_done", 32'(bus.tx_done), 32'd0);
        wait_done();

        // Parity vectors: 07 -> parity 1, 03 -> parity 0
        send(8'h07, 1'b1, 1'b0);
        wait_done();
        send(8'h03, 1'b0, 1'b0);
        wait_done();

        repeat (50) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
